// File: rtl/msync_cmd_decoder.sv
// msync_cmd_decoder
// Decodes the multi-board sync line from the master board into single-cycle
// command pulses for the msync acquisition-enable state machine. The master
// sends one high pulse per command: a short pulse means start, a long pulse
// means stop, and any other width is reported as a framing error.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   sync_in     asynchronous sync line from the master board
//   decode_en   decoder enable; low discards any pulse in progress
//   start_daq   one-cycle pulse: valid start pulse decoded
//   stop_daq    one-cycle pulse: valid stop pulse decoded
//   cmd_err     one-cycle pulse: out-of-range or overlong pulse
//   last_width  width of the most recently classified pulse
//   busy        high while a pulse is measured, awaited low, or in holdoff
module msync_cmd_decoder #(
    parameter int CNT_W     = 16,
    parameter int START_MIN = 8,
    parameter int START_MAX = 15,
    parameter int STOP_MIN  = 24,
    parameter int STOP_MAX  = 31,
    parameter int HOLDOFF   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_in,
    input  logic             decode_en,
    output logic             start_daq,
    output logic             stop_daq,
    output logic             cmd_err,
    output logic [CNT_W-1:0] last_width,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_HIGH,
        ST_WAIT_LOW,
        ST_HOLDOFF
    } state_t;

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  START_LO  = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0]  START_HI  = CNT_W'(START_MAX);
    localparam logic [CNT_W-1:0]  STOP_LO   = CNT_W'(STOP_MIN);
    localparam logic [CNT_W-1:0]  STOP_HI   = CNT_W'(STOP_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_t            state_q;
    logic              s1_q;
    logic              s2_q;
    logic [1:0]        fill_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  last_q;
    logic [HOLD_W-1:0] hcnt_q;
    logic              start_q;
    logic              stop_q;
    logic              err_q;
    logic              busy_q;

    logic in_start;
    logic in_stop;
    logic sync_valid;

    assign in_start = (cnt_q >= START_LO) && (cnt_q <= START_HI);
    assign in_stop  = (cnt_q >= STOP_LO)  && (cnt_q <= STOP_HI);

    // s2 holds its reset value until two samples of sync_in have passed
    // through the chain; ARM must not trust it before then, otherwise a
    // line already high at reset release would look like a fresh edge.
    assign sync_valid = fill_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARM;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            hcnt_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q <= sync_in;
            s2_q <= s1_q;
            if (!fill_q[1]) begin
                fill_q <= fill_q + 2'd1;
            end

            start_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;

            if (!decode_en) begin
                state_q <= ST_ARM;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ARM: begin
                        busy_q <= 1'b0;
                        if (sync_valid && !s2_q) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    ST_IDLE: begin
                        if (s2_q) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end

                    ST_HIGH: begin
                        if (s2_q) begin
                            if (cnt_q == CNT_MAX) begin
                                // Overlong pulse: report once, then ride out the rest.
                                err_q   <= 1'b1;
                                last_q  <= CNT_MAX;
                                state_q <= ST_WAIT_LOW;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            last_q  <= cnt_q;
                            start_q <= in_start;
                            stop_q  <= in_stop;
                            err_q   <= !in_start && !in_stop;
                            if (HOLDOFF == 0) begin
                                state_q <= ST_ARM;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_HOLDOFF;
                                hcnt_q  <= '0;
                            end
                        end
                    end

                    ST_WAIT_LOW: begin
                        if (!s2_q) begin
                            if (HOLDOFF == 0) begin
                                state_q <= ST_ARM;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_HOLDOFF;
                                hcnt_q  <= '0;
                            end
                        end
                    end

                    ST_HOLDOFF: begin
                        if (hcnt_q == HOLD_LAST) begin
                            state_q <= ST_ARM;
                            hcnt_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            hcnt_q <= hcnt_q + HOLD_W'(1);
                        end
                    end

                    default: begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_daq  = start_q;
    assign stop_daq   = stop_q;
    assign cmd_err    = err_q;
    assign last_width = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_msync_cmd_decoder.sv
// Testbench for msync_cmd_decoder: table-driven width vectors, hand-written
// multi-cycle sequences, and randomized traffic checked against a run-length
// reference model. Two instances: default widths and a 6-bit counter.
module tb_msync_cmd_decoder;

    localparam int MAXT = 4096;
    localparam int HOLD = 16;
    localparam int SMIN = 8;
    localparam int SMAX = 15;
    localparam int PMIN = 24;
    localparam int PMAX = 31;

    logic        clk;
    logic        reset;
    logic        decode_en;
    logic        sync_m;
    logic        sync_6;
    logic        start_m, stop_m, err_m, busy_m;
    logic [15:0] last_m;
    logic        start_6, stop_6, err_6, busy_6;
    logic [5:0]  last_6;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    msync_cmd_decoder #(.CNT_W(16), .START_MIN(SMIN), .START_MAX(SMAX),
                        .STOP_MIN(PMIN), .STOP_MAX(PMAX), .HOLDOFF(HOLD)) dut_m (
        .clk(clk), .reset(reset), .sync_in(sync_m), .decode_en(decode_en),
        .start_daq(start_m), .stop_daq(stop_m), .cmd_err(err_m),
        .last_width(last_m), .busy(busy_m));

    msync_cmd_decoder #(.CNT_W(6), .START_MIN(SMIN), .START_MAX(SMAX),
                        .STOP_MIN(PMIN), .STOP_MAX(PMAX), .HOLDOFF(HOLD)) dut_6 (
        .clk(clk), .reset(reset), .sync_in(sync_6), .decode_en(decode_en),
        .start_daq(start_6), .stop_daq(stop_6), .cmd_err(err_6),
        .last_width(last_6), .busy(busy_6));

    int n_checks = 0;
    int n_err    = 0;
    int t        = 0;
    logic daq_m;

    // Per-edge recordings since the last reset release: sync_in as sampled
    // at edge t, and outputs {start,stop,err,busy} / last_width just after it.
    logic        samp_m [MAXT];
    logic        samp_6 [MAXT];
    logic [3:0]  rec_m  [MAXT];
    logic [3:0]  rec_6  [MAXT];
    logic [15:0] lw_m   [MAXT];
    logic [15:0] lw_6   [MAXT];
    logic [3:0]  exp_bits [MAXT];
    int          ev_w     [MAXT];

    typedef struct {
        int         width;
        logic [2:0] kind;   // {start, stop, err}
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic vm, input logic v6);
        sync_m = vm;
        sync_6 = v6;
        @(posedge clk);
        #1;
        if (t < MAXT) begin
            samp_m[t] = vm;
            samp_6[t] = v6;
            rec_m[t]  = {start_m, stop_m, err_m, busy_m};
            rec_6[t]  = {start_6, stop_6, err_6, busy_6};
            lw_m[t]   = last_m;
            lw_6[t]   = {10'd0, last_6};
        end
        if (start_m) daq_m = 1'b1;
        else if (stop_m) daq_m = 1'b0;
        t++;
        @(negedge clk);
    endtask

    task automatic both(input logic v, input int n);
        repeat (n) tick(v, v);
    endtask

    task automatic only6(input logic v, input int n);
        repeat (n) tick(1'b0, v);
    endtask

    task automatic do_reset(input logic sv);
        reset     = 1'b1;
        decode_en = 1'b1;
        sync_m    = sv;
        sync_6    = sv;
        repeat (3) @(negedge clk);
        check("reset_state_m", {start_m, stop_m, err_m, busy_m, last_m}, '0);
        check("reset_state_6", {start_6, stop_6, err_6, busy_6, last_6}, '0);
        reset = 1'b0;
        t     = 0;
        daq_m = 1'b0;
    endtask

    task automatic count_pulses(input bit six, input int lo, input int hi,
                                output int cs, output int cp, output int ce);
        logic [3:0] b;
        cs = 0; cp = 0; ce = 0;
        for (int i = lo; i < hi; i++) begin
            b = six ? rec_6[i] : rec_m[i];
            cs += int'(b[3]);
            cp += int'(b[2]);
            ce += int'(b[1]);
        end
    endtask

    task automatic check_counts(input string name, input bit six, input int lo, input int hi,
                                input int es, input int ep, input int ee);
        int cs, cp, ce;
        count_pulses(six, lo, hi, cs, cp, ce);
        check(name, {cs[15:0], cp[15:0], ce[15:0]}, {es[15:0], ep[15:0], ee[15:0]});
    endtask

    // Command pulses must never coincide nor sit on consecutive cycles.
    task automatic adj_check(input string name, input bit six, input int n);
        int viol;
        int p, q;
        viol = 0;
        for (int i = 0; i < n; i++) begin
            p = $countones(six ? rec_6[i][3:1] : rec_m[i][3:1]);
            if (p > 1) viol++;
            if (i + 1 < n) begin
                q = $countones(six ? rec_6[i+1][3:1] : rec_m[i+1][3:1]);
                if (p > 0 && q > 0) viol++;
            end
        end
        check(name, viol, 0);
    endtask

    // The decoder sees sync_in two edges late.
    function automatic logic yv(input bit six, input int i);
        if (i < 2) return 1'b0;
        return six ? samp_6[i-2] : samp_m[i-2];
    endfunction

    // Run-length reference: walk the delayed line as a list of high runs.
    // A run is accepted only if the decoder became free (ARM) at least one
    // edge before it rose; it is classified when it falls (or at counter
    // saturation), and the decoder is then free again HOLD+1 edges after
    // the line returns low. busy covers the run plus the holdoff.
    task automatic model_check(input string name, input bit six, input int n);
        int maxw, free_at, i, r0, len, w, bad, first_bad, cur;
        logic [2:0] kind;
        logic [3:0] got_b;
        logic [15:0] got_l;
        maxw = six ? 63 : 65535;
        for (int k = 0; k < n; k++) begin
            exp_bits[k] = '0;
            ev_w[k]     = -1;
        end
        free_at = 2;
        i       = 2;
        while (i < n) begin
            if (yv(six, i)) begin
                r0  = i;
                len = 0;
                while (i < n && yv(six, i)) begin
                    len++;
                    i++;
                end
                if (i < n && free_at <= r0 - 1) begin
                    w = (len > maxw) ? maxw : len;
                    if (len > maxw)                  kind = 3'b001;
                    else if (w >= SMIN && w <= SMAX) kind = 3'b100;
                    else if (w >= PMIN && w <= PMAX) kind = 3'b010;
                    else                             kind = 3'b001;
                    exp_bits[r0 + w][3:1] = kind;
                    ev_w[r0 + w] = w;
                    for (int b = r0; b < r0 + len + HOLD && b < n; b++) exp_bits[b][0] = 1'b1;
                    free_at = r0 + len + 1 + HOLD;
                end
            end else begin
                i++;
            end
        end
        bad = 0;
        first_bad = -1;
        cur = 0;
        for (int k = 0; k < n; k++) begin
            if (ev_w[k] >= 0) cur = ev_w[k];
            got_b = six ? rec_6[k] : rec_m[k];
            got_l = six ? lw_6[k] : lw_m[k];
            if ({got_b, got_l} !== {exp_bits[k], cur[15:0]}) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d cycles differ, first at edge %0d: got bits %b width %0d, expected bits %b",
                     name, bad, first_bad,
                     six ? rec_6[first_bad] : rec_m[first_bad],
                     six ? lw_6[first_bad] : lw_m[first_bad], exp_bits[first_bad]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, f, mark, lo, hi, w, g, rm, r6, cs, cp, ce;
        logic kind_stop, exp_daq, lm, l6;

        vt[0]  = '{10, 3'b100};
        vt[1]  = '{28, 3'b010};
        vt[2]  = '{8,  3'b100};
        vt[3]  = '{15, 3'b100};
        vt[4]  = '{24, 3'b010};
        vt[5]  = '{31, 3'b010};
        vt[6]  = '{7,  3'b001};
        vt[7]  = '{16, 3'b001};
        vt[8]  = '{23, 3'b001};
        vt[9]  = '{32, 3'b001};
        vt[10] = '{1,  3'b001};

        reset     = 1'b1;
        decode_en = 1'b1;
        sync_m    = 1'b0;
        sync_6    = 1'b0;
        daq_m     = 1'b0;
        @(negedge clk);

        // Table of widths: one classification per pulse, 2 edges after the low sample.
        do_reset(1'b0);
        both(1'b0, 20);
        foreach (vt[i]) begin
            lo = t;
            both(1'b1, vt[i].width);
            f = t;
            both(1'b0, 22);
            hi = t;
            check_counts($sformatf("vec%0d_w%0d_count", i, vt[i].width), 1'b0, lo, hi,
                         int'(vt[i].kind[2]), int'(vt[i].kind[1]), int'(vt[i].kind[0]));
            check($sformatf("vec%0d_w%0d_at", i, vt[i].width),
                  {rec_m[f+2][3:1], lw_m[f+2]}, {vt[i].kind, 16'(vt[i].width)});
            if (i == 0) begin
                w = 0;
                for (int k = lo; k < hi; k++) w += int'(rec_m[k][0]);
                check("busy_len_w10", w, vt[i].width + HOLD);
                check("busy_span_w10", {rec_m[lo+1][0], rec_m[lo+2][0], rec_m[f+1+HOLD][0], rec_m[f+2+HOLD][0]},
                      4'b0110);
            end
        end
        model_check("model_table_m", 1'b0, t);
        model_check("model_table_6", 1'b1, t);

        // Saturation on the 6-bit instance, then recovery.
        do_reset(1'b0);
        only6(1'b0, 20);
        a = t;
        only6(1'b1, 100);
        only6(1'b0, 30);
        mark = t;
        only6(1'b1, 10);
        f = t;
        only6(1'b0, 25);
        check_counts("timeout_counts", 1'b1, 0, mark, 0, 0, 1);
        check("timeout_at", {rec_6[a+65][3:1], lw_6[a+65]}, {3'b001, 16'd63});
        check("timeout_recover", {rec_6[f+2][3:1], lw_6[f+2]}, {3'b100, 16'd10});
        model_check("model_timeout_6", 1'b1, t);

        // Pulse starting inside holdoff is swallowed.
        do_reset(1'b0);
        both(1'b0, 20);
        both(1'b1, 10);
        both(1'b0, 5);
        both(1'b1, 10);
        both(1'b0, 30);
        mark = t;
        both(1'b1, 10);
        f = t;
        both(1'b0, 25);
        check_counts("holdoff_swallow", 1'b0, 0, mark, 1, 0, 0);
        check("holdoff_after", {rec_m[f+2][3:1], lw_m[f+2]}, {3'b100, 16'd10});
        model_check("model_holdoff_m", 1'b0, t);

        // Line already high through reset release.
        do_reset(1'b1);
        both(1'b1, 20);
        both(1'b0, 30);
        mark = t;
        check_counts("high_at_reset", 1'b0, 0, mark, 0, 0, 0);
        both(1'b1, 10);
        f = t;
        both(1'b0, 25);
        check("high_at_reset_after", {rec_m[f+2][3:1], lw_m[f+2]}, {3'b100, 16'd10});
        model_check("model_hireset_m", 1'b0, t);

        // decode_en dropped in the middle of a 28-cycle pulse.
        do_reset(1'b0);
        both(1'b0, 20);
        both(1'b1, 10);
        both(1'b0, 25);
        mark = t;
        both(1'b1, 12);
        decode_en = 1'b0;
        both(1'b1, 3);
        decode_en = 1'b1;
        both(1'b1, 13);
        both(1'b0, 30);
        check_counts("en_drop_counts", 1'b0, mark, t, 0, 0, 0);
        check("en_drop_busy", {rec_m[mark+11][0], rec_m[mark+12][0]}, 2'b10);
        check("en_drop_last_held", lw_m[t-1], 16'd10);
        both(1'b1, 10);
        f = t;
        both(1'b0, 25);
        check("en_resume", {rec_m[f+2][3:1], lw_m[f+2]}, {3'b100, 16'd10});

        // Random legal command stream; track the enable the commands imply.
        do_reset(1'b0);
        both(1'b0, 20);
        exp_daq = 1'b0;
        for (int k = 0; k < 30; k++) begin
            kind_stop = 1'($urandom_range(1, 0));
            w = kind_stop ? int'($urandom_range(PMAX, PMIN)) : int'($urandom_range(SMAX, SMIN));
            g = int'($urandom_range(HOLD + 12, HOLD + 2));
            both(1'b1, w);
            both(1'b0, g);
            exp_daq = !kind_stop;
            check($sformatf("daq_en_cmd%0d", k), daq_m, exp_daq);
        end
        count_pulses(1'b0, 0, t, cs, cp, ce);
        check("legal_no_err", ce, 0);
        adj_check("legal_adjacent_m", 1'b0, t);
        model_check("model_legal_m", 1'b0, t);
        model_check("model_legal_6", 1'b1, t);

        // Unconstrained random run lengths, independent on each instance.
        do_reset(1'b0);
        both(1'b0, 5);
        lm = 1'b0;
        l6 = 1'b0;
        rm = int'($urandom_range(25, 1));
        r6 = int'($urandom_range(25, 1));
        for (int c = 0; c < 1500; c++) begin
            tick(lm, l6);
            rm--;
            r6--;
            if (rm == 0) begin
                lm = ~lm;
                rm = lm ? int'($urandom_range(40, 1)) : int'($urandom_range(25, 1));
            end
            if (r6 == 0) begin
                l6 = ~l6;
                r6 = l6 ? int'($urandom_range(90, 1)) : int'($urandom_range(25, 1));
            end
        end
        both(1'b0, 40);
        adj_check("random_adjacent_m", 1'b0, t);
        adj_check("random_adjacent_6", 1'b1, t);
        model_check("model_random_m", 1'b0, t);
        model_check("model_random_6", 1'b1, t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
